// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for requesters sharing one tri-state bus, with a forced turnaround between tenures.
// Optional forced release after MAX_HOLD grant cycles is built when the macro ARB_TIMEOUT_EN is defined.
module tristate_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] data_enable_low,
    output logic [2:0]       owner,
    output logic             bus_busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);

    state_t            state_reg, state_next;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic [N_REQ-1:0]  enable_low_reg;
    logic [2:0]        owner_reg, owner_next;
    logic [2:0]        last_owner_reg, last_owner_next;
    logic              bus_busy_reg;
    logic [1:0]        turn_cnt_reg, turn_cnt_next;
    logic [7:0]        hold_cnt_reg, hold_cnt_next;
`ifdef ARB_TIMEOUT_EN
    logic              timeout_reg, timeout_next;
`endif

    logic [N_REQ-1:0]  req_masked;
    logic [N_REQ-1:0]  search;
    logic [N_REQ-1:0]  win_onehot;
    logic [2:0]        win_idx;
    logic              owner_req;

    // Requests strictly above the last owner get first look; wrap to the full vector otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rr
            assign req_masked[gi] = req[gi] & (3'(gi) > last_owner_reg);
            assign win_onehot[gi] = (win_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        search  = (|req_masked) ? req_masked : req;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (search[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    // grant_reg is one-hot on the owner during GRANT, so this avoids indexing req by owner.
    assign owner_req = |(req & grant_reg);

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        turn_cnt_next   = turn_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
`ifdef ARB_TIMEOUT_EN
        timeout_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                grant_next = '0;
                if (|req) begin
                    state_next      = GRANT;
                    grant_next      = win_onehot;
                    owner_next      = win_idx;
                    last_owner_next = win_idx;
                    hold_cnt_next   = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_next    = TURN;
                    grant_next    = '0;
                    turn_cnt_next = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_reg == HOLD_LAST) begin
                    // last_owner already points at the preempted requester, so it loses priority next round
                    state_next    = TURN;
                    grant_next    = '0;
                    turn_cnt_next = '0;
                    timeout_next  = 1'b1;
                end
`endif
                else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            TURN: begin
                grant_next = '0;
                if (turn_cnt_reg == TURN_LAST) begin
                    state_next = IDLE;
                end else begin
                    turn_cnt_next = turn_cnt_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            enable_low_reg <= '1;
            owner_reg      <= '0;
            last_owner_reg <= 3'(N_REQ - 1);
            bus_busy_reg   <= 1'b0;
            turn_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            enable_low_reg <= ~grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            bus_busy_reg   <= |grant_next;
            turn_cnt_reg   <= turn_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
`ifdef ARB_TIMEOUT_EN
            timeout_reg    <= timeout_next;
`endif
        end
    end

    assign grant           = grant_reg;
    assign data_enable_low = enable_low_reg;
    assign owner           = owner_reg;
    assign bus_busy        = bus_busy_reg;
`ifdef ARB_TIMEOUT_EN
    assign timeout         = timeout_reg;
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: reset, round-robin rotation, non-owner isolation,
// asynchronous reset release, wrap-around and (with ARB_TIMEOUT_EN) forced release.
module tb_tristate_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b1111;
    logic [3:0] grant;
    logic [3:0] data_enable_low;
    logic [2:0] owner;
    logic       bus_busy;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int total = 0;
    int bad = 0;

    tristate_bus_arbiter #(
        .N_REQ   (4),
        .TURN_CYC(1),
        .MAX_HOLD(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .data_enable_low(data_enable_low),
        .owner          (owner),
        .bus_busy       (bus_busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout        (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_inv();
        logic [3:0] inv_grant;
        logic [31:0] ones;
        inv_grant = ~grant;
        ones = 32'($countones(grant));
        chk("enable_is_inverse", 32'(data_enable_low), 32'(inv_grant));
        chk("grant_onehot0", 32'(ones <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_inv();
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [2:0] o);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_busy"}, 32'(bus_busy), 32'(g != 4'b0000));
        if (g != 4'b0000) chk({tag, "_owner"}, 32'(owner), 32'(o));
    endtask

    logic [3:0] seq_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] seq_o [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    initial begin
        // Reset with all requests high
        tick();
        tick();
        chk_grant("rst", 4'b0000, 3'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_del", 32'(data_enable_low), 32'hf);
        reset = 1'b0;
        tick();
        chk("first_del", 32'(data_enable_low), 32'he);

        // Rotation: each owner holds 3 cycles then drops for one cycle
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 3; c++) begin
                if (c > 0) tick();
                chk_grant($sformatf("rr%0d_c%0d", t, c), seq_g[t], seq_o[t]);
            end
            if (t < 4) begin
                req = 4'b1111 & ~seq_g[t];
                tick();
                chk_grant($sformatf("rr%0d_turn", t), 4'b0000, 3'd0);
                req = 4'b1111;
                tick();
                chk_grant($sformatf("rr%0d_idle", t), 4'b0000, 3'd0);
                tick();
            end
        end

        // Non-owner requests during GRANT are ignored
        req = 4'b0000;
        tick();
        tick();
        tick();
        chk_grant("drain", 4'b0000, 3'd0);
        req = 4'b0100;
        tick();
        chk_grant("own2", 4'b0100, 3'd2);
        req = 4'b1110;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_grant($sformatf("own2_hold%0d", c), 4'b0100, 3'd2);
        end
        req = 4'b1010;
        tick();
        chk_grant("own2_turn", 4'b0000, 3'd0);
        tick();
        chk_grant("own2_idle", 4'b0000, 3'd0);
        tick();
        chk_grant("own3", 4'b1000, 3'd3);

        // Asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        chk_inv();
        chk_grant("async_rst", 4'b0000, 3'd0);
        chk("async_rst_del", 32'(data_enable_low), 32'hf);
        req = 4'b0000;
        tick();
        chk("async_rst_owner", 32'(owner), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk_grant("post_rst_idle", 4'b0000, 3'd0);
        req = 4'b0010;
        tick();
        chk_grant("post_rst_first", 4'b0010, 3'd1);

        // Wrap-around from owner 3 back to 0
        req = 4'b1000;
        tick();
        tick();
        tick();
        tick();
        chk_grant("wrap_own3", 4'b1000, 3'd3);
        req = 4'b0011;
        tick();
        tick();
        tick();
        chk_grant("wrap_own0", 4'b0001, 3'd0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD=4 cycles
        reset = 1'b1;
        req = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_grant($sformatf("to_hold%0d", c), 4'b0001, 3'd0);
            chk($sformatf("to_pulse_lo%0d", c), 32'(timeout), 32'd0);
        end
        tick();
        chk_grant("to_turn", 4'b0000, 3'd0);
        chk("to_pulse", 32'(timeout), 32'd1);
        tick();
        chk_grant("to_idle", 4'b0000, 3'd0);
        chk("to_pulse_end", 32'(timeout), 32'd0);
        tick();
        chk_grant("to_next", 4'b0010, 3'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one tri-state bus; legal range 2..8.
REQ-002 Parameter TURN_CYC, default 1: bus turnaround length in cycles, all drivers off; legal range 1..4.
REQ-003 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  level request per requester; bit i held high while requester i wants the bus.
REQ-007 grant  output  N_REQ  registered one-hot-or-zero grant.
REQ-008 data_enable_low  output  N_REQ  registered active-low driver enables for the per-requester bufif0 drivers; 0 = drive the bus.
REQ-009 owner  output  3  registered index of the current grantee; valid only while bus_busy=1.
REQ-010 bus_busy  output  1  registered; 1 while any grant bit is set.
REQ-011 timeout  output  1  registered single-cycle pulse on forced release; present only with ARB_TIMEOUT_EN (REQ-030).

Function
REQ-012 FSM states: IDLE, GRANT, TURN; registered outputs only, no combinational path from req to any output.
REQ-013 data_enable_low SHALL equal the bitwise inverse of grant on every cycle; at most one bit of data_enable_low is 0.
REQ-014 IDLE: if req != 0 at an edge, that edge enters GRANT with grant set to the round-robin winner; otherwise IDLE holds with grant=0.
REQ-015 Latency: grant is visible in the cycle directly after the edge that samples req high from IDLE (1 cycle).
REQ-016 Round-robin: the winner is the first asserted req bit searching upward from (last_owner+1) modulo N_REQ, wrapping past N_REQ-1 to 0.
REQ-017 last_owner updates to the winner on every IDLE->GRANT transition.
REQ-018 GRANT: a hold counter clears on entry and increments each cycle the grant remains.
REQ-019 GRANT exits to TURN at the edge where req[owner]=0; grant and all drivers turn off in the same cycle.
REQ-020 Requests from non-owners during GRANT or TURN SHALL not affect grant; they are evaluated only in IDLE.
REQ-021 TURN lasts exactly TURN_CYC cycles with grant=0, then enters IDLE; a new grant is therefore never earlier than TURN_CYC+1 cycles after the previous grant drops.
REQ-022 owner and bus_busy update on the same edge as grant.
REQ-023 A simultaneous req[owner] fall and hold-limit hit is a normal release; timeout SHALL stay 0.
REQ-024 Illegal FSM encodings SHALL recover to IDLE on the next edge with grant=0.

Reset
REQ-025 While reset=1: state=IDLE, grant=0, data_enable_low all ones, owner=0, bus_busy=0, timeout=0, hold counter=0.
REQ-026 last_owner resets to N_REQ-1, so requester 0 has top priority after reset.
REQ-027 Reset asserted mid-GRANT SHALL release all drivers immediately (asynchronous), without waiting for a clock edge.
REQ-028 After reset deasserts, the first arbitration decision occurs at the first edge with req != 0.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN controls forced release.
REQ-030 With ARB_TIMEOUT_EN defined: GRANT exits to TURN when the hold counter reaches MAX_HOLD-1 with req[owner] still high; timeout pulses for 1 cycle coincident with the first TURN cycle; the round-robin pointer moves past the preempted requester.
REQ-031 Without ARB_TIMEOUT_EN: no timeout port and no hold limit; a grant persists until req[owner] falls; the hold counter may be omitted.

Verification
REQ-032 Reset with req=4'b1111, then release reset: grant=4'b0001 one cycle later and data_enable_low=4'b1110.
REQ-033 req=4'b1111 held, each owner drops req for one cycle after 3 grant cycles (TURN_CYC=1): grant sequence 0001,0010,0100,1000,0001, with 1 all-off cycle plus the IDLE decision cycle between tenures.
REQ-034 Owner 2 granted; req[1] and req[3] rise during GRANT: grant stays 4'b0100 until req[2] falls, then 4'b1000 is granted after TURN.
REQ-035 Every cycle of every test: data_enable_low == ~grant and $countones(grant) <= 1, so no two drivers enable together.
REQ-036 ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held: grant 0001 for exactly 4 cycles, timeout pulse, turnaround, then grant 0010.
REQ-037 Reset asserted during GRANT between clock edges: grant=0 and data_enable_low all ones before the next edge.
